pol_rd_arb: RTL and testbench
=============================

Name: pol_rd_arb

Overview:
- Shares one GLB feature-map read port among POOL_CORE pooling cores.
- Round-robin arbitrates per-core address requests and issues them to the GLB through a registered address stage.
- Records the granted core index in an in-order tag FIFO.
- Routes each returned feature-map word back to the core that issued the request. Sits between the pooling cores' memory-fetch logic and the GLB read port.

Parameters:
- POOL_CORE, 6, number of requesting pooling cores.
- POOL_COMP_CORE, 64, activations per returned word.
- IDX_WIDTH, 10, read address width.
- ACT_WIDTH, 8, bits per activation.
- OUT_DEPTH, 4, maximum outstanding (issued, not yet returned) reads; tag FIFO depth.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; synchronous, active-high (1 = reset), despite the name.
- POLARB_AddrVld  in  POOL_CORE  per-core read request valid.
- POLARB_Addr  in  IDX_WIDTH*POOL_CORE  per-core read address; core i at [IDX_WIDTH*i +: IDX_WIDTH].
- ARBPOL_AddrRdy  out  POOL_CORE  one-hot grant; request accepted when Vld&Rdy.
- ARBGLB_AddrVld  out  1  GLB address valid (registered).
- ARBGLB_Addr  out  IDX_WIDTH  GLB address (registered).
- GLBARB_AddrRdy  in  1  GLB accepts address.
- GLBARB_Fm  in  ACT_WIDTH*POOL_COMP_CORE  returned word.
- GLBARB_FmVld  in  1  returned word valid.
- ARBGLB_FmRdy  out  1  ready for returned word.
- ARBPOL_Fm  out  ACT_WIDTH*POOL_COMP_CORE  word broadcast to all cores.
- ARBPOL_FmVld  out  POOL_CORE  one-hot destination valid.
- POLARB_FmRdy  in  POOL_CORE  per-core data ready.
- ARBPOL_Idle  out  1  no request in the address stage and tag FIFO empty.
- ARBPOL_Err  out  1  sticky protocol error.

Behaviour:
- Reset (rst_n=1): ARBGLB_AddrVld=0, ARBGLB_Addr=0, tag FIFO empty with pointers=0, RR last-grant pointer=POOL_CORE-1 (core 0 highest priority), ARBPOL_Err=0, ARBPOL_Idle=1. All combinational outputs follow from these states.
- Reset mid-operation drops the address stage and all tags. The GLB must be reset in the same cycle.
- Load condition: load = |POLARB_AddrVld & (!ARBGLB_AddrVld | GLBARB_AddrRdy) & (fifo_cnt < OUT_DEPTH).
- Grant: ARBPOL_AddrRdy = load ? rr_onehot : 0. rr_onehot selects the first requester after the last-grant pointer, wrapping POOL_CORE-1 -> 0.
- Requesters hold Vld/Addr stable until Rdy. Rdy never depends on the requester's own Vld deasserting.
- On load:
  - address register <= granted address and ARBGLB_AddrVld <= 1;
  - tag (granted index, TAG_W = $clog2(POOL_CORE) bits) is pushed into the FIFO;
  - last-grant pointer <= granted index.
- Issue latency: 1 cycle from request acceptance to ARBGLB_AddrVld.
- GLB accept without a new load: ARBGLB_AddrVld <= 0.
- Stalled stage: if ARBGLB_AddrVld=1 and GLBARB_AddrRdy=0, address and valid hold and no grant is issued.
- Back-to-back throughput: 1 address per cycle when the GLB is ready and credit is available.
- Return path is combinational, zero latency:
  - ARBPOL_Fm = GLBARB_Fm;
  - ARBPOL_FmVld = onehot(head_tag) & {POOL_CORE{GLBARB_FmVld & !empty}};
  - ARBGLB_FmRdy = !empty & POLARB_FmRdy[head_tag].
- Pop the tag on GLBARB_FmVld & ARBGLB_FmRdy. Data is returned in issue order.
- Push and pop in the same cycle leave fifo_cnt unchanged. The pointers wrap at OUT_DEPTH.
- Full FIFO (fifo_cnt == OUT_DEPTH): no grants. A pop in that cycle frees credit only from the next cycle.
- GLBARB_FmVld=1 while the FIFO is empty: ARBGLB_FmRdy=0, ARBPOL_FmVld=0, and ARBPOL_Err sets and holds until reset.
- ARBPOL_Idle = !ARBGLB_AddrVld & empty.

Optional Feature:
- Macro POL_RD_ARB_PERF_EN.
- When defined:
  - adds output ARBPOL_GntCnt [32*POOL_CORE], a per-core saturating grant counter incremented on each grant;
  - adds output ARBPOL_StallCnt [32], a saturating count of cycles with |POLARB_AddrVld and no grant;
  - all counters clear on reset.
- When undefined: these ports and counters do not exist. The rest of the behaviour is identical.

Decomposition:
- Shared pool package holds:
  - TAG_W = $clog2(POOL_CORE) helper;
  - word width constant ACT_WIDTH*POOL_COMP_CORE;
  - perf counter width 32.
- One sub-module, pol_rr_arb: parameterised round-robin one-hot arbiter with request vector, advance enable and last-grant pointer.
- The tag FIFO stays inline (small register array).

Test Plan:
- Single request: reset, core 3 requests addr 0x12A with GLB always ready -> ARBPOL_AddrRdy=6'b001000 in cycle 0. ARBGLB_AddrVld=1, Addr=0x12A in cycle 1. GLB returns a word -> ARBPOL_FmVld=6'b001000, Err=0.
- Round-robin fairness: all 6 cores request continuously with GLB ready and data returned in 1 cycle -> grant order 0,1,2,3,4,5,0 and each core granted once per 6 grants.
- Credit limit: OUT_DEPTH=4, GLB accepts addresses but withholds data -> exactly 4 grants, then AddrRdy=0. Returning one word -> one new grant one cycle later.
- Address backpressure: GLBARB_AddrRdy=0 for 5 cycles with core 1 requesting 0x055 -> ARBGLB_Addr holds 0x055 and no further grants occur. On release, the next grant appears the same cycle.
- Return backpressure: head tag = core 2 with POLARB_FmRdy[2]=0 and other cores ready -> ARBGLB_FmRdy=0 and the word is held. Raising FmRdy[2] delivers it.
- Protocol error and reset: FmVld=1 with no outstanding read -> Err=1 sticky, FmRdy=0. rst_n=1 for one cycle mid-burst -> Idle=1, Err=0, FIFO empty.

Source files
------------

// File: rtl/pol_rd_arb_pkg.sv
// Shared definitions for the pooling-core GLB read arbiter: tag width, word width
// and performance-counter width.
package pol_rd_arb_pkg;

   localparam int PERF_W      = 32;
   localparam int ACT_W_DEF   = 8;
   localparam int COMP_CORE_D = 64;
   localparam int WORD_W_DEF  = ACT_W_DEF * COMP_CORE_D;

   typedef logic [PERF_W-1:0] perf_cnt_t;

   // Index width for n items; never below one bit so single-entry configs still elaborate.
   function automatic int tag_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int word_w(input int act_w, input int comp_core);
      return act_w * comp_core;
   endfunction

endpackage

// File: rtl/pol_rr_arb.sv
// Round-robin one-hot arbiter: the first requester after the last grant wins,
// and the last-grant pointer advances only when the caller accepts the grant.
module pol_rr_arb
   import pol_rd_arb_pkg::*;
#(
   parameter int N     = 6,
   parameter int IDX_W = tag_w(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             adv,
   output logic [N-1:0]     gnt_oh,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] last_ptr;

   always_comb begin
      logic found;
      int   j;
      gnt_oh  = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      // Scan N positions starting just after the last grant, wrapping N-1 -> 0.
      for (int k = 1; k <= N; k++) begin
         j = int'(last_ptr) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found      = 1'b1;
            gnt_oh[j]  = 1'b1;
            gnt_idx    = IDX_W'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_ptr <= IDX_W'(N - 1);
      end else if (adv) begin
         last_ptr <= gnt_idx;
      end
   end

endmodule

// File: rtl/pol_rd_arb.sv
// Shares one GLB feature-map read port among POOL_CORE pooling cores: round-robin
// address issue through a registered stage, in-order tag FIFO, combinational
// return routing. Define POL_RD_ARB_PERF_EN to add grant/stall counters.
module pol_rd_arb
   import pol_rd_arb_pkg::*;
#(
   parameter int POOL_CORE      = 6,
   parameter int POOL_COMP_CORE = 64,
   parameter int IDX_WIDTH      = 10,
   parameter int ACT_WIDTH      = 8,
   parameter int OUT_DEPTH      = 4
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [POOL_CORE-1:0]                      POLARB_AddrVld,
   input  logic [IDX_WIDTH*POOL_CORE-1:0]            POLARB_Addr,
   output logic [POOL_CORE-1:0]                      ARBPOL_AddrRdy,
   output logic                                      ARBGLB_AddrVld,
   output logic [IDX_WIDTH-1:0]                      ARBGLB_Addr,
   input  logic                                      GLBARB_AddrRdy,
   input  logic [word_w(ACT_WIDTH,POOL_COMP_CORE)-1:0] GLBARB_Fm,
   input  logic                                      GLBARB_FmVld,
   output logic                                      ARBGLB_FmRdy,
   output logic [word_w(ACT_WIDTH,POOL_COMP_CORE)-1:0] ARBPOL_Fm,
   output logic [POOL_CORE-1:0]                      ARBPOL_FmVld,
   input  logic [POOL_CORE-1:0]                      POLARB_FmRdy,
`ifdef POL_RD_ARB_PERF_EN
   output logic [PERF_W*POOL_CORE-1:0]               ARBPOL_GntCnt,
   output logic [PERF_W-1:0]                         ARBPOL_StallCnt,
`endif
   output logic                                      ARBPOL_Idle,
   output logic                                      ARBPOL_Err
);

   localparam int TAG_W = tag_w(POOL_CORE);
   localparam int PTR_W = tag_w(OUT_DEPTH);
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);

   // rst_n is active-high despite its name.
   logic rst;
   assign rst = rst_n;

   logic                 vld_p1;
   logic [IDX_WIDTH-1:0] addr_p1;

   logic [TAG_W-1:0]     tag_mem [OUT_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     fifo_cnt;
   logic                 err_q;

   logic                 any_req;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 load;
   logic                 push;
   logic                 pop;
   logic [POOL_CORE-1:0] gnt_oh;
   logic [TAG_W-1:0]     gnt_idx;
   logic [IDX_WIDTH-1:0] gnt_addr;
   logic [TAG_W-1:0]     head_tag;
   logic [POOL_CORE-1:0] head_oh;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign any_req    = |POLARB_AddrVld;
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_W'(OUT_DEPTH));

   // Credit is judged on the registered count, so a pop while full frees a slot next cycle.
   assign load = any_req & (~vld_p1 | GLBARB_AddrRdy) & ~fifo_full;
   assign push = load;

   pol_rr_arb #(
      .N     (POOL_CORE),
      .IDX_W (TAG_W)
   ) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (POLARB_AddrVld),
      .adv     (load),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx)
   );

   assign ARBPOL_AddrRdy = load ? gnt_oh : '0;

   always_comb begin
      gnt_addr = '0;
      for (int i = 0; i < POOL_CORE; i++) begin
         if (gnt_oh[i]) gnt_addr = gnt_addr | POLARB_Addr[IDX_WIDTH*i +: IDX_WIDTH];
      end
   end

   // ---- stage p1: registered GLB address ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
      end else if (load) begin
         vld_p1  <= 1'b1;
         addr_p1 <= gnt_addr;
      end else if (GLBARB_AddrRdy) begin
         vld_p1  <= 1'b0;
      end
   end

   assign ARBGLB_AddrVld = vld_p1;
   assign ARBGLB_Addr    = addr_p1;

   assign head_tag = tag_mem[rd_ptr];

   always_comb begin
      head_oh = '0;
      for (int i = 0; i < POOL_CORE; i++) begin
         head_oh[i] = (head_tag == TAG_W'(i));
      end
   end

   assign ARBPOL_Fm    = GLBARB_Fm;
   assign ARBPOL_FmVld = head_oh & {POOL_CORE{GLBARB_FmVld & ~fifo_empty}};
   assign ARBGLB_FmRdy = ~fifo_empty & (|(head_oh & POLARB_FmRdy));
   assign pop          = GLBARB_FmVld & ARBGLB_FmRdy;

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= gnt_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // A returned word with nothing outstanding is a GLB protocol violation; latch it.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (GLBARB_FmVld & fifo_empty) begin
         err_q <= 1'b1;
      end
   end

   assign ARBPOL_Err  = err_q;
   assign ARBPOL_Idle = ~vld_p1 & fifo_empty;

`ifdef POL_RD_ARB_PERF_EN
   perf_cnt_t gnt_cnt_q [POOL_CORE];
   perf_cnt_t stall_cnt_q;

   function automatic perf_cnt_t sat_inc(input perf_cnt_t v);
      return (v == '1) ? v : v + perf_cnt_t'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < POOL_CORE; i++) gnt_cnt_q[i] <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int i = 0; i < POOL_CORE; i++) begin
            if (ARBPOL_AddrRdy[i]) gnt_cnt_q[i] <= sat_inc(gnt_cnt_q[i]);
         end
         if (any_req & ~load) stall_cnt_q <= sat_inc(stall_cnt_q);
      end
   end

   always_comb begin
      ARBPOL_GntCnt = '0;
      for (int i = 0; i < POOL_CORE; i++) begin
         ARBPOL_GntCnt[PERF_W*i +: PERF_W] = gnt_cnt_q[i];
      end
   end

   assign ARBPOL_StallCnt = stall_cnt_q;
`else
   // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_pol_rd_arb.sv
// Randomized scoreboard bench for pol_rd_arb against a queue-based reference model.
module tb_pol_rd_arb;

   localparam int NC    = 6;
   localparam int IW    = 10;
   localparam int WW    = 512;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [NC-1:0]     req_vld;
   logic [IW-1:0]     req_addr [NC];
   logic [IW*NC-1:0]  addr_bus;
   logic              glb_addr_rdy;
   logic [WW-1:0]     glb_fm;
   logic              glb_fm_vld;
   logic [NC-1:0]     core_fm_rdy;

   logic [NC-1:0]     addr_rdy;
   logic              glb_vld;
   logic [IW-1:0]     glb_addr;
   logic              glb_fm_rdy;
   logic [WW-1:0]     pol_fm;
   logic [NC-1:0]     pol_fm_vld;
   logic              idle;
   logic              err;

   always_comb begin
      addr_bus = '0;
      for (int i = 0; i < NC; i++) addr_bus[IW*i +: IW] = req_addr[i];
   end

   pol_rd_arb dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .POLARB_AddrVld (req_vld),
      .POLARB_Addr    (addr_bus),
      .ARBPOL_AddrRdy (addr_rdy),
      .ARBGLB_AddrVld (glb_vld),
      .ARBGLB_Addr    (glb_addr),
      .GLBARB_AddrRdy (glb_addr_rdy),
      .GLBARB_Fm      (glb_fm),
      .GLBARB_FmVld   (glb_fm_vld),
      .ARBGLB_FmRdy   (glb_fm_rdy),
      .ARBPOL_Fm      (pol_fm),
      .ARBPOL_FmVld   (pol_fm_vld),
      .POLARB_FmRdy   (core_fm_rdy),
      .ARBPOL_Idle    (idle),
      .ARBPOL_Err     (err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Stimulus knobs
   int            req_prob     = 0;
   int            glb_rdy_prob = 100;
   int            fm_vld_prob  = 100;
   int            fm_rdy_prob  = 100;
   logic [NC-1:0] req_mask     = '1;
   int            fixed_addr   = -1;
   bit            bogus_fm     = 1'b0;
   int            pend         = 0;

   // Reference model: address stage occupancy, granted-but-unreturned cores in order,
   // last winner, sticky error.
   int            m_last;
   bit            m_stage;
   logic [IW-1:0] m_addr;
   int            m_tags[$];
   bit            m_err;
   int            gnt_total = 0;
   bit            fair_on   = 1'b0;
   int            fair_n    = 0;
   int            fair_cnt [NC];

   int            win;
   bit            ld;
   bit            head;
   logic [NC-1:0] e_gnt;
   logic [NC-1:0] e_fvld;
   bit            e_frdy;

   always @(negedge clk) begin
      if (rst_n) begin
         m_last  = NC - 1;
         m_stage = 1'b0;
         m_addr  = '0;
         m_tags.delete();
         m_err   = 1'b0;
      end else begin
         win = -1;
         for (int k = 1; k <= NC; k++) begin
            if (win < 0 && req_vld[(m_last + k) % NC]) win = (m_last + k) % NC;
         end
         ld     = (win >= 0) && (!m_stage || glb_addr_rdy) && (m_tags.size() < DEPTH);
         e_gnt  = ld ? (NC'(1) << win) : '0;
         head   = (m_tags.size() > 0);
         e_fvld = '0;
         e_frdy = 1'b0;
         if (head) begin
            if (glb_fm_vld) e_fvld = NC'(1) << m_tags[0];
            e_frdy = core_fm_rdy[m_tags[0]];
         end

         chk("grant",    addr_rdy,   e_gnt);
         chk("glb_vld",  glb_vld,    m_stage);
         chk("glb_addr", glb_addr,   m_addr);
         chk("fm_vld",   pol_fm_vld, e_fvld);
         chk("fm_rdy",   glb_fm_rdy, e_frdy);
         if (glb_fm_vld) chk("fm_data", pol_fm, glb_fm);
         chk("err",      err,        m_err);
         chk("idle",     idle,       !m_stage && !head);

         if (glb_fm_vld && e_frdy) void'(m_tags.pop_front());
         if (glb_fm_vld && !head) m_err = 1'b1;
         if (ld) begin
            m_stage = 1'b1;
            m_addr  = req_addr[win];
            m_tags.push_back(win);
            m_last  = win;
            gnt_total++;
            if (fair_on && fair_n < 10 * NC) begin
               fair_cnt[win]++;
               fair_n++;
            end
         end else if (m_stage && glb_addr_rdy) begin
            m_stage = 1'b0;
         end
      end
   end

   task automatic rand_word();
      for (int w = 0; w < WW / 32; w++) glb_fm[32*w +: 32] = $urandom;
   endtask

   task automatic cycle();
      logic [NC-1:0] g;
      bit            aacc;
      bit            facc;
      @(negedge clk);
      g    = addr_rdy;
      aacc = glb_vld && glb_addr_rdy;
      facc = glb_fm_vld && glb_fm_rdy;
      if (aacc) pend++;
      if (facc) pend--;
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++) begin
         if (!(req_vld[i] && !g[i])) begin
            req_vld[i]  = req_mask[i] && ($urandom_range(99) < req_prob);
            req_addr[i] = (fixed_addr >= 0) ? IW'(fixed_addr) : IW'($urandom);
         end
      end
      glb_addr_rdy = ($urandom_range(99) < glb_rdy_prob);
      if (bogus_fm) begin
         glb_fm_vld = 1'b1;
         rand_word();
      end else if (glb_fm_vld && !facc && pend > 0) begin
         glb_fm_vld = 1'b1;
      end else if (pend > 0 && $urandom_range(99) < fm_vld_prob) begin
         glb_fm_vld = 1'b1;
         rand_word();
      end else begin
         glb_fm_vld = 1'b0;
      end
      for (int i = 0; i < NC; i++) core_fm_rdy[i] = ($urandom_range(99) < fm_rdy_prob);
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) cycle();
   endtask

   task automatic do_reset(input int n);
      rst_n        = 1'b1;
      req_vld      = '0;
      for (int i = 0; i < NC; i++) req_addr[i] = '0;
      glb_addr_rdy = 1'b1;
      glb_fm_vld   = 1'b0;
      glb_fm       = '0;
      core_fm_rdy  = '1;
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b0;
      pend  = 0;
   endtask

   task automatic set_knobs(input int rp, input int gp, input int fv, input int fr);
      req_prob     = rp;
      glb_rdy_prob = gp;
      fm_vld_prob  = fv;
      fm_rdy_prob  = fr;
   endtask

   task automatic drain();
      req_mask   = '1;
      fixed_addr = -1;
      set_knobs(0, 100, 100, 100);
      run(20);
   endtask

   initial begin
      int n0;
      for (int i = 0; i < NC; i++) fair_cnt[i] = 0;
      do_reset(3);

      // Single request from core 3
      req_mask   = 6'b001000;
      fixed_addr = 12'h12A;
      set_knobs(100, 100, 100, 100);
      run(1);
      req_prob = 0;
      run(6);

      // Round-robin fairness with all cores requesting continuously
      req_mask   = '1;
      fixed_addr = -1;
      set_knobs(100, 100, 100, 100);
      run(2);
      fair_on = 1'b1;
      run(150);
      fair_on = 1'b0;
      chk("fair_total", fair_n, 10 * NC);
      for (int i = 0; i < NC; i++) chk($sformatf("fair_core%0d", i), fair_cnt[i], 10);

      // Credit limit: addresses accepted, data withheld
      drain();
      n0 = gnt_total;
      set_knobs(100, 100, 0, 100);
      run(15);
      chk("credit_grants", gnt_total - n0, DEPTH);
      fm_vld_prob = 100;
      run(10);

      // Address backpressure on core 1
      drain();
      req_mask   = 6'b000010;
      fixed_addr = 12'h055;
      set_knobs(100, 0, 100, 100);
      run(6);
      set_knobs(0, 100, 100, 100);
      run(6);

      // Random traffic, moderate then heavy return backpressure
      drain();
      set_knobs(40, 70, 60, 60);
      run(600);
      set_knobs(90, 50, 30, 25);
      run(600);

      // Returned word with nothing outstanding
      drain();
      bogus_fm = 1'b1;
      run(2);
      bogus_fm = 1'b0;
      run(3);
      set_knobs(70, 80, 70, 70);
      run(20);

      // Reset in the middle of a burst
      do_reset(1);
      set_knobs(70, 80, 70, 50);
      run(200);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
